// File: rtl/friscv_pkg.sv
// Shared RISC-V decode definitions: datapath defaults, base opcodes and instruction formats.
package friscv_pkg;

  localparam int ARCH          = 32;
  localparam int REGFILE_DEPTH = 32;

  localparam logic [6:0] REG       = 7'b0110011;
  localparam logic [6:0] IMM_ARITH = 7'b0010011;
  localparam logic [6:0] IMM_LOAD  = 7'b0000011;
  localparam logic [6:0] IMM_JUMP  = 7'b1100111;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] U_L_LOAD  = 7'b0110111;
  localparam logic [6:0] U_AUIPC   = 7'b0010111;
  localparam logic [6:0] JUMP      = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } instr_fmt_t;

  // Unlisted opcodes map to FMT_NONE, which the decoder treats as illegal.
  function automatic instr_fmt_t fmt_of(input logic [6:0] op);
    instr_fmt_t f;
    case (op)
      REG:                           f = FMT_R;
      IMM_ARITH, IMM_LOAD, IMM_JUMP: f = FMT_I;
      STORE:                         f = FMT_S;
      BRANCH:                        f = FMT_B;
      U_L_LOAD, U_AUIPC:             f = FMT_U;
      JUMP:                          f = FMT_J;
      default:                       f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction; builds a sign-extended 32-bit value, then widens to ARCH.
module imm_gen
  import friscv_pkg::*;
#(
  parameter int ARCH = friscv_pkg::ARCH
) (
  input  logic [31:0]     instr,
  input  instr_fmt_t      fmt,
  output logic [ARCH-1:0] imm
);

  logic [31:0] imm32;
  logic        unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // ARCH-31 is at least 1, so this replication is never empty for 32 or 64.
  assign imm = {{(ARCH-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/decode_stage.sv
// Single-entry registered decode stage with valid/ready handshake on both sides.
module decode_stage
  import friscv_pkg::*;
#(
  parameter int ARCH          = friscv_pkg::ARCH,
  parameter int REGFILE_DEPTH = friscv_pkg::REGFILE_DEPTH,
  localparam int RW           = $clog2(REGFILE_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_in,
  input  logic            instr_valid_in,
  output logic            instr_ready_out,
  input  logic [31:0]     instr_in,
  input  logic [ARCH-1:0] pc_in,
  output logic            dec_valid_out,
  input  logic            dec_ready_in,
  output logic [6:0]      op_code_out,
  output logic [2:0]      func3_out,
  output logic [6:0]      func7_out,
  output logic [RW-1:0]   rs1_out,
  output logic [RW-1:0]   rs2_out,
  output logic [RW-1:0]   rd_out,
  output logic [ARCH-1:0] imm_out,
  output logic [ARCH-1:0] pc_out,
  output instr_fmt_t      fmt_out,
  output logic            illegal_out
);

  instr_fmt_t      raw_fmt, fmt_d;
  logic            use_rd, use_rs1, use_rs2, use_f7;
  logic            bad_reg, illegal_d, accept;
  logic [2:0]      func3_d;
  logic [6:0]      func7_d;
  logic [RW-1:0]   rs1_d, rs2_d, rd_d;
  logic [ARCH-1:0] imm_d;

  assign instr_ready_out = !dec_valid_out || dec_ready_in;
  assign accept          = instr_valid_in && instr_ready_out && !flush_in;

  always_comb begin
    raw_fmt = (instr_in[1:0] == 2'b11) ? fmt_of(instr_in[6:0]) : FMT_NONE;
    use_rd  = raw_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};
    use_rs1 = raw_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    use_rs2 = raw_fmt inside {FMT_R, FMT_S, FMT_B};
    use_f7  = (raw_fmt == FMT_R);
    // RV32E only has x0..x15; any used index reaching x16+ is illegal.
    bad_reg = (REGFILE_DEPTH == 16) && ((use_rd && instr_in[11]) ||
                                        (use_rs1 && instr_in[19]) ||
                                        (use_rs2 && instr_in[24]));
    illegal_d = (raw_fmt == FMT_NONE) || bad_reg;
    fmt_d     = illegal_d ? FMT_NONE : raw_fmt;
    rd_d      = (!illegal_d && use_rd)  ? instr_in[7 +: RW]  : '0;
    rs1_d     = (!illegal_d && use_rs1) ? instr_in[15 +: RW] : '0;
    rs2_d     = (!illegal_d && use_rs2) ? instr_in[20 +: RW] : '0;
    func3_d   = (!illegal_d && use_rs1) ? instr_in[14:12]    : '0;
    func7_d   = (!illegal_d && use_f7)  ? instr_in[31:25]    : '0;
  end

  imm_gen #(
    .ARCH (ARCH)
  ) u_imm_gen (
    .instr (instr_in),
    .fmt   (fmt_d),
    .imm   (imm_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_valid_out <= 1'b0;
      op_code_out   <= '0;
      func3_out     <= '0;
      func7_out     <= '0;
      rs1_out       <= '0;
      rs2_out       <= '0;
      rd_out        <= '0;
      imm_out       <= '0;
      pc_out        <= '0;
      fmt_out       <= FMT_NONE;
      illegal_out   <= 1'b0;
    end else if (flush_in) begin
      dec_valid_out <= 1'b0;
    end else if (accept) begin
      dec_valid_out <= 1'b1;
      op_code_out   <= instr_in[6:0];
      func3_out     <= func3_d;
      func7_out     <= func7_d;
      rs1_out       <= rs1_d;
      rs2_out       <= rs2_d;
      rd_out        <= rd_d;
      imm_out       <= imm_d;
      pc_out        <= pc_in;
      fmt_out       <= fmt_d;
      illegal_out   <= illegal_d;
    end else if (dec_ready_in) begin
      dec_valid_out <= 1'b0;
    end
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter ARCH, default friscv_pkg::ARCH (32), SHALL set the datapath width for immediate and PC; legal values are 32 and 64.
REQ-002 Parameter REGFILE_DEPTH, default 32, SHALL set register index width RW = $clog2(REGFILE_DEPTH); legal values are 16 (RV32E) and 32.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 flush_in  in  1  discards the held decode result.
REQ-006 instr_valid_in  in  1 / instr_ready_out  out  1  upstream handshake.
REQ-007 instr_in  in  32  raw instruction / pc_in  in  ARCH  instruction address.
REQ-008 dec_valid_out  out  1 / dec_ready_in  in  1  downstream handshake.
REQ-009 op_code_out 7, func3_out 3, func7_out 7, rs1_out/rs2_out/rd_out RW, imm_out ARCH, pc_out ARCH, fmt_out instr_fmt_t, illegal_out 1: all outputs, all registered.

Function
REQ-010 Transfers SHALL occur only when valid and ready are both high in the same cycle.
REQ-011 instr_ready_out SHALL equal (!dec_valid_out || dec_ready_in) combinationally; no other input-to-output combinational path exists.
REQ-012 An accepted instruction SHALL appear on the outputs with dec_valid_out=1 in the following cycle (latency 1); back-to-back acceptance SHALL sustain one instruction per cycle.
REQ-013 While dec_valid_out=1 and dec_ready_in=0, every output SHALL hold its value.
REQ-014 When a result is consumed and no new instruction is accepted, dec_valid_out SHALL go to 0 next cycle; data outputs may keep stale values.
REQ-015 flush_in=1 SHALL clear dec_valid_out next cycle and SHALL block acceptance that cycle regardless of instr_valid_in (flush dominates).
REQ-016 Format selection: OP -> R; OP_IMM, LOAD, JALR -> I; STORE -> S; BRANCH -> B; LUI, AUIPC -> U; JAL -> J.
REQ-017 Immediates SHALL be sign-extended from instr_in[31] to ARCH bits: I = instr[31:20]; S = {instr[31:25], instr[11:7]}; B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}; U = {instr[31:12], 12'b0}; J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}; R -> 0.
REQ-018 Fields unused by the selected format (rd, rs1, rs2, func3, func7) SHALL be driven 0; op_code_out always = instr_in[6:0].
REQ-019 Register indices SHALL be the low RW bits of instr[11:7], [19:15], [24:20].
REQ-020 illegal_out SHALL be 1, with fmt_out=FMT_NONE and all fields except op_code_out zero, when instr_in[1:0]!=2'b11, the opcode is unlisted, or REGFILE_DEPTH=16 and any used register field has bit 4 set; illegal instructions still complete the handshake.
REQ-021 pc_out SHALL be the pc_in captured with the instruction.

Reset
REQ-022 On rst assertion, dec_valid_out, illegal_out, and all data outputs SHALL go to 0 immediately, with fmt_out=FMT_NONE.
REQ-023 An instruction in flight at reset SHALL be lost; the first accepted instruction after rst deasserts SHALL decode normally.

Structure
REQ-024 friscv_pkg SHALL hold the opcode constants (REG, IMM_ARITH, IMM_LOAD, IMM_JUMP, STORE, BRANCH, U_L_LOAD, U_AUIPC, JUMP), instr_fmt_t {FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J}, ARCH, and REGFILE_DEPTH.
REQ-025 Decode SHALL live in one combinational sub-module, imm_gen (instr, fmt -> ARCH-bit immediate); the handshake register stays in decode_stage.

Verification
REQ-026 ADDI x1,x2,-1 (0xFFF10093), ready=1 -> next cycle valid=1, rd=1, rs1=2, rs2=0, imm=0xFFFFFFFF, fmt=FMT_I.
REQ-027 BEQ x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, rd=0, func3=0, fmt=FMT_B; LUI x5,0x12345 (0x123452B7) -> imm=0x12345000, rd=5.
REQ-028 Hold dec_ready_in=0 for 3 cycles with a second instruction pending -> instr_ready_out=0, outputs stable; when ready rises, the second instruction appears one cycle later.
REQ-029 flush_in=1 together with a valid input and a held result -> dec_valid_out=0 next cycle, input not accepted, nothing emitted.
REQ-030 0x00000000 -> illegal_out=1, valid=1; REGFILE_DEPTH=16 with ADD x16,x1,x2 (0x00208833) -> illegal_out=1.
REQ-031 Assert rst mid-stall -> outputs 0 asynchronously; ADDI after release decodes as in REQ-026.
